// File: rtl/rv0_pbuf.sv
// rv0_pbuf: DEPTH-deep rdy/ack pipeline buffer with occupancy count and flush.
// Optional same-cycle pass-through when empty: define RV0_PBUF_BYPASS_EN.
module rv0_pbuf #(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [DW-1:0] data_i,
    input  logic          rdy_i,
    output logic          ack_o,
    output logic [DW-1:0] data_o,
    output logic          rdy_o,
    input  logic          ack_i,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic push;
    logic push_st;
    logic pop_st;

    assign empty   = (count_q == '0);
    // Full-ness alone gates ack_o, so ack_i never reaches the producer.
    assign ack_o   = (count_q != FULL);
    assign count_o = count_q;
    assign push    = rdy_i && ack_o;
    assign pop_st  = !empty && ack_i;

`ifdef RV0_PBUF_BYPASS_EN
    logic bypass;
    assign bypass  = empty && rdy_i && !flush_i;
    assign rdy_o   = !empty || bypass;
    assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
    // A bypassed item taken downstream this cycle is never stored.
    assign push_st = push && !(bypass && ack_i);
`else
    assign rdy_o   = !empty;
    assign data_o  = mem_q[rd_ptr_q];
    assign push_st = push;
`endif

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_st) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_st) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_st, pop_st})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
